// File: rtl/mul_div_ctrl.sv
// ---------------------------------------------------------------------------
// mul_div_ctrl
//
// Iterative 32-bit multiply/divide unit that produces the HI/LO register pair
// of a MIPS-style pipeline. It retires one result bit per cycle, and every
// operation has the same fixed latency.
//
// Sequence: IDLE/DONE --start--> PREP (1) -> RUN (32) -> FIX (1) -> DONE (1)
//   start accepted on edge 0 : busy during cycles 1..34, done in cycle 35.
//
// Build option:
//   MUL_DIV_SIGNED_EN  when defined, op[0] selects signed MULT/DIV.
//                      When undefined, op[0] is ignored and every operation
//                      is unsigned.
//
// Ports:
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous, active-high reset
//   start    in   1   begin an operation (sampled in IDLE or DONE only)
//   op       in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a        in   32  multiplicand / dividend
//   b        in   32  multiplier / divisor
//   hilo_rd  in   1   pipeline is issuing MFHI/MFLO this cycle
//   hi       out  32  product[63:32] or remainder
//   lo       out  32  product[31:0] or quotient
//   busy     out  1   operation in progress (PREP, RUN, FIX)
//   done     out  1   one-cycle pulse; hi/lo hold the new result
//   div0     out  1   pulses with done when a divide had b == 0
//   stall    out  1   hilo_rd & busy
// ---------------------------------------------------------------------------
module mul_div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        hilo_rd,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div0,
    output logic        stall
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic        accept;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        is_div_r;
    logic        div0_r;
    logic [31:0] opnd;        // multiplicand or divisor magnitude during RUN
    logic [63:0] acc;         // mult: {partial, multiplier}; div: {rem, quotient}
    logic [4:0]  cnt;

    logic        sgn_a;
    logic        sgn_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;

    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic [32:0] div_shift;
    logic [33:0] div_diff;
    logic [63:0] div_step;
    logic        div_diff_unused;

    logic [31:0] res_hi;
    logic [31:0] res_lo;

`ifdef MUL_DIV_SIGNED_EN
    logic is_signed_r;
    logic neg_res;            // quotient / product sign
    logic neg_rem;            // remainder follows the dividend

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] cond_neg64(input logic [63:0] v, input logic neg);
        return neg ? (~v + 64'd1) : v;
    endfunction

    assign sgn_a = is_signed_r & a_r[31];
    assign sgn_b = is_signed_r & b_r[31];
    assign mag_a = cond_neg32(a_r, sgn_a);
    assign mag_b = cond_neg32(b_r, sgn_b);
`else
    logic op0_unused;

    assign op0_unused = op[0];
    assign sgn_a      = 1'b0;
    assign sgn_b      = 1'b0;
    assign mag_a      = a_r;
    assign mag_b      = b_r;
`endif

    assign accept = start && ((state == IDLE) || (state == DONE));

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? PREP : IDLE;
            PREP:    state_nxt = RUN;
            RUN:     state_nxt = (cnt == 5'd31) ? FIX : RUN;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? PREP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy  = (state == PREP) || (state == RUN) || (state == FIX);
        done  = (state == DONE);
        div0  = (state == DONE) && div0_r;
        stall = hilo_rd && busy;
    end

    // -----------------------------------------------------------------------
    // RUN step: multiply, shift-add
    // The multiplier sits in acc[31:0] and is consumed LSB first. The
    // partial product builds up in acc[63:32], and the whole accumulator
    // shifts right once per cycle.
    // -----------------------------------------------------------------------
    assign mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
    assign mul_step = {mul_sum, acc[31:1]};

    // -----------------------------------------------------------------------
    // RUN step: divide, restoring shift-subtract
    // The dividend sits in acc[31:0] and is consumed MSB first. The partial
    // remainder is in acc[63:32]. Because the remainder is always below the
    // divisor, the shifted value fits in 33 bits. A borrow out of bit 33
    // means "restore".
    // With a zero divisor, every step subtracts nothing. This leaves
    // quotient = all ones and remainder = dividend.
    // -----------------------------------------------------------------------
    assign div_shift       = {acc[63:32], acc[31]};
    assign div_diff        = {1'b0, div_shift} - {2'b00, opnd};
    assign div_diff_unused = div_diff[32];
    assign div_step        = div_diff[33] ? {div_shift[31:0], acc[30:0], 1'b0}
                                          : {div_diff[31:0],  acc[30:0], 1'b1};

    // -----------------------------------------------------------------------
    // FIX: result selection and sign correction
    // -----------------------------------------------------------------------
    always_comb begin
        res_hi = acc[63:32];
        res_lo = acc[31:0];
`ifdef MUL_DIV_SIGNED_EN
        if (is_div_r) begin
            res_hi = cond_neg32(acc[63:32], neg_rem);
            res_lo = cond_neg32(acc[31:0], neg_res);
        end else begin
            {res_hi, res_lo} = cond_neg64(acc, neg_res);
        end
`endif
        // A divide by zero reports the raw dividend, whatever the signedness.
        if (div0_r) begin
            res_hi = a_r;
            res_lo = 32'hFFFF_FFFF;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            is_div_r <= 1'b0;
            div0_r   <= 1'b0;
            opnd     <= 32'd0;
            acc      <= 64'd0;
            cnt      <= 5'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
`ifdef MUL_DIV_SIGNED_EN
            is_signed_r <= 1'b0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                a_r      <= a;
                b_r      <= b;
                is_div_r <= op[1];
`ifdef MUL_DIV_SIGNED_EN
                is_signed_r <= op[0];
`endif
            end

            case (state)
                PREP: begin
                    cnt    <= 5'd0;
                    div0_r <= is_div_r && (b_r == 32'd0);
                    if (is_div_r) begin
                        acc  <= {32'd0, mag_a};
                        opnd <= mag_b;
                    end else begin
                        acc  <= {32'd0, mag_b};
                        opnd <= mag_a;
                    end
`ifdef MUL_DIV_SIGNED_EN
                    neg_res <= sgn_a ^ sgn_b;
                    neg_rem <= sgn_a;
`endif
                end
                RUN: begin
                    cnt <= cnt + 5'd1;
                    acc <= is_div_r ? div_step : mul_step;
                end
                FIX: begin
                    hi <= res_hi;
                    lo <= res_lo;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_ctrl.sv
module tb_mul_div_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hilo_rd;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div0;
    logic        stall;

    int n_tests = 0;
    int n_fail  = 0;

    // Cycle c (1..35) of an operation is stored in bit c-1.
    localparam logic [34:0] BUSY_EXP = 35'h3_FFFF_FFFF;
    localparam logic [34:0] DONE_EXP = 35'h4_0000_0000;

`ifdef MUL_DIV_SIGNED_EN
    localparam logic [31:0] MULT_HI = 32'hFFFF_FFFF;
    localparam logic [31:0] MULT_LO = 32'hFFFF_FFEB;
    localparam logic [31:0] DIV_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_LO  = 32'hFFFF_FFFD;
    localparam logic [31:0] OVF_HI  = 32'h0000_0000;
    localparam logic [31:0] OVF_LO  = 32'h8000_0000;
`else
    localparam logic [31:0] MULT_HI = 32'h0000_0006;
    localparam logic [31:0] MULT_LO = 32'hFFFF_FFEB;
    localparam logic [31:0] DIV_HI  = 32'h0000_0001;
    localparam logic [31:0] DIV_LO  = 32'h7FFF_FFFC;
    localparam logic [31:0] OVF_HI  = 32'h8000_0000;
    localparam logic [31:0] OVF_LO  = 32'h0000_0000;
`endif

    mul_div_ctrl dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .hilo_rd (hilo_rd),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .div0    (div0),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: returns {hi, lo}, computed with plain arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        bit     sg;
        longint sx, sy, sp, q, r;
        sg = 1'b0;
`ifdef MUL_DIV_SIGNED_EN
        sg = o[0];
`endif
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!o[1]) begin
            if (sg) begin
                sp = sx * sy;
                return sp;
            end
            return {32'd0, x} * {32'd0, y};
        end
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (sg) begin
            q = sx / sy;
            r = sx % sy;
            return {r[31:0], q[31:0]};
        end
        return {x % y, x / y};
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'd1;
            2:       v = 32'hFFFF_FFFF;
            3:       v = 32'h8000_0000;
            4:       v = 32'h7FFF_FFFF;
            5:       v = 32'($urandom_range(0, 255));
            default: ;
        endcase
        return v;
    endfunction

    // Drives one operation and records what the DUT does in cycles 1..35.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit rd, input bit chain, input bit restart10,
                          output logic [34:0] busy_v, output logic [34:0] done_v,
                          output logic [34:0] stall_v, output bit hold_bad,
                          output logic [31:0] hi_o, output logic [31:0] lo_o,
                          output logic div0_o);
        logic [31:0] hi0, lo0;
        if (!chain) @(negedge clk);
        hi0      = hi;
        lo0      = lo;
        op       = o;
        a        = x;
        b        = y;
        hilo_rd  = rd;
        start    = 1'b1;
        hold_bad = 1'b0;
        busy_v   = '0;
        done_v   = '0;
        stall_v  = '0;
        hi_o     = '0;
        lo_o     = '0;
        div0_o   = 1'b0;
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            busy_v[c-1]  = busy;
            done_v[c-1]  = done;
            stall_v[c-1] = stall;
            if (c < 35 && (hi !== hi0 || lo !== lo0)) hold_bad = 1'b1;
            if (c == 35) begin
                hi_o   = hi;
                lo_o   = lo;
                div0_o = div0;
            end
            start = restart10 && (c == 10);
            if (restart10 && c == 10) begin
                a = 32'hDEAD_BEEF;
                b = 32'd3;
                op = 2'b00;
            end
        end
        start   = 1'b0;
        hilo_rd = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; hilo_rd = 1'b1;
        #2;
        n_tests++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_tests++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_tests++; if ({busy, done, div0, stall} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_ctrl: busy/done/div0/stall got %b want 0000", {busy, done, div0, stall}); end
        repeat (2) @(negedge clk);
        reset = 1'b0; hilo_rd = 1'b0;
    endtask

    task automatic test_multu_max();
        logic [34:0] bv, dv, sv; bit hb; logic [31:0] h, l; logic d0;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, bv, dv, sv, hb, h, l, d0);
        n_tests++; if (bv !== BUSY_EXP) begin n_fail++; $display("FAIL multu_busy: got %h want %h", bv, BUSY_EXP); end
        n_tests++; if (dv !== DONE_EXP) begin n_fail++; $display("FAIL multu_done: got %h want %h", dv, DONE_EXP); end
        n_tests++; if (h !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", h); end
        n_tests++; if (l !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 00000001", l); end
        n_tests++; if (hb !== 1'b0) begin n_fail++; $display("FAIL multu_hold: hi/lo changed early, got %b want 0", hb); end
    endtask

    task automatic test_signed_vectors();
        logic [34:0] bv, dv, sv; bit hb; logic [31:0] h, l; logic d0;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0, 0, 0, bv, dv, sv, hb, h, l, d0);
        n_tests++; if ({h, l} !== {MULT_HI, MULT_LO}) begin n_fail++;
            $display("FAIL mult_neg: got %h_%h want %h_%h", h, l, MULT_HI, MULT_LO); end
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, bv, dv, sv, hb, h, l, d0);
        n_tests++; if ({h, l} !== {DIV_HI, DIV_LO}) begin n_fail++;
            $display("FAIL div_neg: got %h_%h want %h_%h", h, l, DIV_HI, DIV_LO); end
        n_tests++; if (d0 !== 1'b0) begin n_fail++; $display("FAIL div_neg_div0: got %b want 0", d0); end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, bv, dv, sv, hb, h, l, d0);
        n_tests++; if ({h, l} !== {OVF_HI, OVF_LO}) begin n_fail++;
            $display("FAIL div_ovf: got %h_%h want %h_%h", h, l, OVF_HI, OVF_LO); end
    endtask

    task automatic test_div0();
        logic [34:0] bv, dv, sv; bit hb; logic [31:0] h, l; logic d0;
        run_op(2'b10, 32'd100, 32'd0, 0, 0, 0, bv, dv, sv, hb, h, l, d0);
        n_tests++; if (h !== 32'd100) begin n_fail++; $display("FAIL divu0_hi: got %h want 00000064", h); end
        n_tests++; if (l !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo: got %h want ffffffff", l); end
        n_tests++; if (d0 !== 1'b1) begin n_fail++; $display("FAIL divu0_flag: got %b want 1", d0); end
        n_tests++; if (dv !== DONE_EXP) begin n_fail++; $display("FAIL divu0_latency: got %h want %h", dv, DONE_EXP); end
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 0, 0, 0, bv, dv, sv, hb, h, l, d0);
        n_tests++; if ({h, l, d0} !== {32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1}) begin n_fail++;
            $display("FAIL div0_neg: got %h_%h div0=%b want fffffffb_ffffffff div0=1", h, l, d0); end
    endtask

    task automatic test_stall_restart();
        logic [34:0] bv, dv, sv; bit hb; logic [31:0] h, l; logic d0;
        run_op(2'b10, 32'd1000, 32'd7, 1, 0, 1, bv, dv, sv, hb, h, l, d0);
        n_tests++; if (sv !== BUSY_EXP) begin n_fail++; $display("FAIL stall_trace: got %h want %h", sv, BUSY_EXP); end
        n_tests++; if (dv !== DONE_EXP) begin n_fail++; $display("FAIL restart_done: got %h want %h", dv, DONE_EXP); end
        n_tests++; if ({h, l} !== {32'd6, 32'd142}) begin n_fail++;
            $display("FAIL restart_result: got %h_%h want 00000006_0000008e", h, l); end
    endtask

    task automatic test_back_to_back();
        logic [34:0] bv, dv, sv; bit hb; logic [31:0] h, l; logic d0;
        logic [63:0] e;
        run_op(2'b00, 32'd12345, 32'd678, 0, 0, 0, bv, dv, sv, hb, h, l, d0);
        hilo_rd = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_done: got %b want 0", stall); end
        n_tests++; if ({hi, lo} !== 64'd8369910) begin n_fail++;
            $display("FAIL b2b_first: got %h_%h want %h", hi, lo, 64'd8369910); end
        e = model(2'b01, 32'hFFFF_0001, 32'd3);
        run_op(2'b01, 32'hFFFF_0001, 32'd3, 1, 1, 0, bv, dv, sv, hb, h, l, d0);
        n_tests++; if (sv !== BUSY_EXP) begin n_fail++; $display("FAIL b2b_stall: got %h want %h", sv, BUSY_EXP); end
        n_tests++; if (dv !== DONE_EXP) begin n_fail++; $display("FAIL b2b_done: got %h want %h", dv, DONE_EXP); end
        n_tests++; if ({h, l} !== e) begin n_fail++; $display("FAIL b2b_second: got %h_%h want %h", h, l, e); end
    endtask

    task automatic test_reset_midop();
        logic [34:0] bv, dv, sv; bit hb; logic [31:0] h, l; logic d0;
        bit seen;
        @(negedge clk);
        op = 2'b00; a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        n_tests++; if ({hi, lo} !== 64'd0) begin n_fail++; $display("FAIL rst_mid_hilo: got %h_%h want 0", hi, lo); end
        n_tests++; if ({busy, done} !== 2'b00) begin n_fail++;
            $display("FAIL rst_mid_ctrl: busy/done got %b want 00", {busy, done}); end
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        @(negedge clk);
        if (done) seen = 1'b1;
        run_op(2'b00, 32'd40000, 32'd50000, 0, 0, 0, bv, dv, sv, hb, h, l, d0);
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b want 0", seen); end
        n_tests++; if (dv !== DONE_EXP) begin n_fail++; $display("FAIL rst_restart_done: got %h want %h", dv, DONE_EXP); end
        n_tests++; if ({h, l} !== 64'd2000000000) begin n_fail++;
            $display("FAIL rst_restart_result: got %h_%h want %h", h, l, 64'd2000000000); end
    endtask

    task automatic test_random();
        logic [34:0] bv, dv, sv; bit hb; logic [31:0] h, l; logic d0;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [63:0] e;
        for (int i = 0; i < 30; i++) begin
            o = 2'($urandom_range(0, 3));
            x = pick();
            y = pick();
            e = model(o, x, y);
            run_op(o, x, y, 1'($urandom_range(0, 1)), 0, 0, bv, dv, sv, hb, h, l, d0);
            n_tests++; if (h !== e[63:32]) begin n_fail++;
                $display("FAIL rand_hi[%0d] op=%b a=%h b=%h: got %h want %h", i, o, x, y, h, e[63:32]); end
            n_tests++; if (l !== e[31:0]) begin n_fail++;
                $display("FAIL rand_lo[%0d] op=%b a=%h b=%h: got %h want %h", i, o, x, y, l, e[31:0]); end
            n_tests++; if (d0 !== (o[1] && y == 32'd0)) begin n_fail++;
                $display("FAIL rand_div0[%0d] op=%b b=%h: got %b", i, o, y, d0); end
            n_tests++; if (bv !== BUSY_EXP || dv !== DONE_EXP) begin n_fail++;
                $display("FAIL rand_timing[%0d]: busy %h done %h want %h %h", i, bv, dv, BUSY_EXP, DONE_EXP); end
            n_tests++; if (hb !== 1'b0) begin n_fail++; $display("FAIL rand_hold[%0d]: got %b want 0", i, hb); end
        end
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_signed_vectors();
        test_div0();
        test_stall_restart();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
